// File: rtl/lid_relay_chain.sv
// Latency-insensitive relay chain: 1 cycle forward, 1 cycle backward per stage, 2 slots per stage.
// Stop is registered per stage, so o_stop never depends combinationally on i_stop (except N_STAGES=0).
module lid_relay_station #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_v,
  output logic             out_stop,
  output logic [WIDTH-1:0] out_d,
  output logic             out_v,
  input  logic             down_stop
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_d, aux_d, main_nxt, aux_nxt;
  logic             accept, take;

  assign out_stop = (state == FULL);
  assign out_v    = (state != EMPTY);
  assign out_d    = main_d;
  assign accept   = in_v && !out_stop;
  assign take     = out_v && !down_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_d <= '0;
      aux_d  <= '0;
    end else begin
      state  <= state_nxt;
      main_d <= main_nxt;
      aux_d  <= aux_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_d;
    aux_nxt   = aux_d;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = HALF;
          main_nxt  = in_d;
        end
      end
      HALF: begin
        if (take && accept) begin
          main_nxt = in_d;
        end else if (take) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = FULL;
          aux_nxt   = in_d;
        end
      end
      FULL: begin
        // stop is high here, so nothing can be accepted in this state
        if (take) begin
          state_nxt = HALF;
          main_nxt  = aux_d;
          aux_nxt   = '0;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end
endmodule

module lid_relay_chain #(
  parameter int WIDTH    = 16,
  parameter int N_STAGES = 2,
  parameter int OCC_W    = (N_STAGES == 0) ? 1 : $clog2(2*N_STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_stop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_stop,
  output logic [OCC_W-1:0] o_occupancy
);
  generate
    if (N_STAGES == 0) begin : g_bypass
      assign o_data      = i_data;
      assign o_valid     = i_valid;
      assign o_stop      = i_stop;
      assign o_occupancy = '0;
    end else begin : g_chain
      logic [WIDTH-1:0] d [0:N_STAGES];
      logic             v [0:N_STAGES];
      logic             s [0:N_STAGES];
      logic             up_acc, dn_take;
      logic [OCC_W-1:0] occ;

      assign d[0]        = i_data;
      assign v[0]        = i_valid;
      assign s[N_STAGES] = i_stop;
      assign o_stop      = s[0];
      assign o_data      = d[N_STAGES];
      assign o_valid     = v[N_STAGES];

      for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        lid_relay_station #(.WIDTH(WIDTH)) u_stage (
          .clk       (clk),
          .reset     (reset),
          .in_d      (d[k]),
          .in_v      (v[k]),
          .out_stop  (s[k]),
          .out_d     (d[k+1]),
          .out_v     (v[k+1]),
          .down_stop (s[k+1])
        );
      end

      // Internal stage-to-stage moves conserve tokens, so only chain-boundary transfers change the count.
      assign up_acc  = i_valid && !s[0];
      assign dn_take = v[N_STAGES] && !i_stop;

      always_ff @(posedge clk) begin
        if (reset) begin
          occ <= '0;
        end else begin
          case ({up_acc, dn_take})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
          endcase
        end
      end

      assign o_occupancy = occ;
    end
  endgenerate
endmodule

// File: doc/lid_relay_chain.md
Name: lid_relay_chain

Overview:
- Parametrised chain of N_STAGES latency-insensitive relay stations for valid/stop channels between two shells, e.g. between cascaded FIR stages.
- Each stage adds 1 cycle forward latency (data/valid) and 1 cycle backward latency (stop), so round-trip latency is 2*N_STAGES.
- Tokens are never dropped or duplicated, and order is preserved under arbitrary backpressure.
- Adds an occupancy output and a zero-stage pass-through mode.

Parameters:
- WIDTH, 16, data width in bits (signed payload, passed through unchanged).
- N_STAGES, 2, number of relay stations; 0 = combinational pass-through.
- OCC_W, $clog2(2*N_STAGES+1) (minimum 1), width of o_occupancy.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- i_data  input  WIDTH  upstream token payload.
- i_valid  input  1  upstream token valid; 0 = void token.
- o_stop  output  1  backpressure to upstream; registered.
- o_data  output  WIDTH  downstream token payload.
- o_valid  output  1  downstream token valid.
- i_stop  input  1  backpressure from downstream.
- o_occupancy  output  OCC_W  count of valid tokens held in the chain, range 0..2*N_STAGES.

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- Reset values:
  - o_valid=0, o_stop=0, o_data=0, o_occupancy=0.
  - Every stage empty: main and aux slots invalid, data registers 0.
  - Reset mid-operation discards all held tokens on the next edge.
- Per-stage signals:
  - in_v/in_d/in_stop come from upstream: the previous stage, or the chain ports for stage 0.
  - accept = in_v && !out_stop_reg.
  - take = main_v && !down_stop.
- Per-stage FSM, 3 states:
  - EMPTY:
    - accept -> HALF, main<=in_d.
    - else stay.
  - HALF:
    - take && accept -> HALF, main<=in_d.
    - take && !accept -> EMPTY.
    - !take && accept -> FULL, aux<=in_d.
    - !take && !accept -> stay.
  - FULL:
    - take -> HALF, main<=aux, aux cleared.
    - else stay.
    - accept is impossible in FULL because stop is high.
- Stage outputs:
  - Stage stop output = (state==FULL), taken directly from the state register; no combinational path from i_stop to o_stop.
  - Stage data/valid outputs = main slot; main_d holds its last value when main invalid.
- Void tokens (in_v=0) are never stored; they occupy no slot.
- o_occupancy = sum over stages of main_v+aux_v, updated with the state registers (registered).
- Simultaneous events:
  - Input accept and output take in the same cycle keep occupancy unchanged.
  - Data moves main->downstream while new data enters main; no bubble is inserted.
- Latency:
  - Empty chain, i_stop=0: a token presented at edge t appears on o_data/o_valid after N_STAGES edges.
  - Downstream i_stop asserted at edge t: chain o_stop rises no later than N_STAGES edges later, and only once the corresponding stages are FULL.
- Capacity: exactly 2*N_STAGES tokens. Upstream must honour o_stop in the same cycle it is sampled; tokens presented while o_stop=1 are ignored (not accepted).
- N_STAGES=0: o_data=i_data, o_valid=i_valid, o_stop=i_stop, o_occupancy=0, with no registers.
- Throughput: with i_stop=0 permanently, one token per cycle sustained.

Test Plan:
- Pass-through, N_STAGES=2, i_stop=0, tokens 0..199 on every cycle -> o_data = 0..199 in order, first o_valid exactly 2 cycles after first input, o_occupancy steady at 2.
- Full stall, N_STAGES=2, i_stop=1 permanently, i_valid=1 with data 10,11,12,... -> exactly 4 tokens accepted (10..13), o_stop=1 from then on, o_occupancy=4; release i_stop -> 10,11,12,13 emerge in order with no duplicates.
- Random backpressure: i_stop and i_valid each random 50%, payload 0..199 -> every value received exactly once in order; o_occupancy never exceeds 4; no change on o_data while o_valid=1 and i_stop=1.
- Bubbles: i_valid toggles 1,0,1,0 with data 5,X,6,X -> output valid tokens 5,6 only; void cycles never raise o_occupancy.
- Reset mid-operation: load 3 tokens, assert reset one cycle -> next cycle o_valid=0, o_stop=0, o_occupancy=0; subsequent token 42 emerges after 2 cycles.
- N_STAGES=0: i_stop toggled, data 7 -> o_stop follows i_stop combinationally, o_data=7 the same cycle, o_occupancy=0.
